bin_to_bcd_seq: RTL
===================

# bin_to_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the BCD digit-validation stage and turns unsigned binary words into packed BCD digits. Every produced digit is always in the range 0–9, so the validation stage passes them through unmodified. Input and output use valid/ready handshakes, so the block can be stalled from either side.

## Interface
- BIN_W, 16: width of the unsigned binary input; also the number of SHIFT cycles per conversion.
- DIGITS, 5: number of BCD output digits. The integrator must guarantee 10^DIGITS > 2^BIN_W − 1; the defaults satisfy this (65535 < 100000).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  `bin` holds a word to convert.
- in_ready  out  1  block can accept a word (IDLE only).
- bin  in  BIN_W  unsigned binary operand; sampled only on accept.
- out_valid  out  1  `bcd` holds a completed result.
- out_ready  in  1  downstream accepts the result.
- bcd  out  4*DIGITS  packed BCD. Digit i occupies [4i+3:4i]; digit 0 is the least significant.

## Operation
- Single clock, one synchronous active-high reset. No other clocks or resets.
- FSM states are IDLE, SHIFT and DONE. `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- **IDLE:**
  - On `in_valid & in_ready` at an edge: load the binary shift register with `bin`, clear the BCD working register, set `cnt` = BIN_W, go to SHIFT.
  - Otherwise remain in IDLE.
- **SHIFT:** one operation per cycle.
  - Add 3 to every working digit ≥ 5.
  - Shift the combined {working BCD, binary} register left by 1. The binary MSB enters BCD bit 0.
  - Decrement `cnt`.
  - On the edge where `cnt` goes 1→0, copy the post-shift working register into the `bcd` output register and go to DONE.
- **DONE:**
  - `bcd` is held stable.
  - On `out_valid & out_ready` at an edge, go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- The `bcd` output register changes only on the SHIFT→DONE transition and on reset. It keeps the last result through IDLE and the following SHIFT.
- `in_valid` and `bin` are ignored outside IDLE. Words offered while busy are not captured; the upstream must hold them until `in_ready`.
- Working digits never exceed 9 after any step, given the DIGITS constraint. No overflow flag exists.
- Reset asserted at an edge in any state:
  - state → IDLE, `cnt` → 0;
  - working register and `bcd` → 0;
  - any in-flight conversion is discarded;
  - reset has priority over handshakes in the same cycle.

## Timing
- Reset values, visible after the first edge with `reset` = 1: `in_ready` = 1, `out_valid` = 0, `bcd` = 0.
- Accept at edge k → `out_valid` = 1 and `bcd` valid after edge k+BIN_W (default: 16 cycles).
- Output transfer at edge m → `in_ready` = 1 after edge m. The earliest next accept is edge m+1.
- Minimum initiation interval is BIN_W+2 cycles (18 by default): 1 IDLE + BIN_W SHIFT + 1 DONE cycle, with `out_ready` tied high.
- No combinational path from `in_valid` or `out_ready` to any output. All outputs derive from registered state.
- `bin` = 0 takes the full BIN_W cycles; there is no early termination.

## Test plan
- **Reset, then `bin` = 0:** `in_ready` = 1 and `out_valid` = 0 after reset. Accepting `bin` = 0 → `out_valid` exactly 16 edges later with `bcd` = 20'h00000.
- **Values 1234, 65535, 9, 10, 59999:** `bcd` = 20'h01234, 20'h65535, 20'h00009, 20'h00010, 20'h59999 respectively. Every nibble is ≤ 9.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles after `out_valid` → `out_valid` and `bcd` stay stable and `in_ready` stays 0. Raise `out_ready` → one transfer, `in_ready` = 1 on the next cycle.
- **Busy input:** while in SHIFT, drive `in_valid` = 1 with `bin` = 777 → not captured, and the result matches the originally accepted word. 777 is accepted only once IDLE is re-entered.
- **Reset mid-SHIFT:** assert `reset` 5 cycles after accepting 4321 → no `out_valid`, `bcd` = 0, and `in_ready` = 1 after the reset edge. A subsequent 4321 converts to 20'h04321.
- **Back-to-back:** `out_ready` = 1 and `in_valid` = 1 continuously over 100 random words → results match a reference model in order, with exactly 18 cycles per result.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// Upstream word channel (in_*, bin) and downstream result channel (out_*, bcd).
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;

   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, bcd
   );

   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, bcd
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD, one bit per clock; result BIN_W cycles after accept.
// Accepts only in IDLE; a completed result is held in DONE until out_ready (full backpressure).
module bin_to_bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic           clk,
   input  logic           reset,
   bin_to_bcd_seq_if.slave io
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int ALL_W = BCD_W + BIN_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [BIN_W-1:0]   bin_sr;
   logic [BCD_W-1:0]   work;
   logic [BCD_W-1:0]   work_adj;
   logic [BCD_W-1:0]   work_sh;
   logic [BIN_W-1:0]   bin_sh;
   logic [ALL_W-1:0]   shifted;
   logic [BCD_W-1:0]   bcd_q;
   logic               accept;
   logic               last_bit;

   // Add-3 correction: any digit >= 5 becomes >= 8 so the shift carries into the next digit.
   always_comb begin
      work_adj = work;
      for (int i = 0; i < DIGITS; i++) begin
         if (work[4*i +: 4] >= 4'd5) begin
            work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
         end
      end
   end

   assign shifted  = {work_adj, bin_sr} << 1;
   assign work_sh  = shifted[ALL_W-1:BIN_W];
   assign bin_sh   = shifted[BIN_W-1:0];

   assign accept   = (state == IDLE) && io.in_valid;
   assign last_bit = (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io.in_valid)  state_nxt = SHIFT;
         SHIFT:   if (last_bit)     state_nxt = DONE;
         DONE:    if (io.out_ready) state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         bin_sr <= '0;
         work   <= '0;
         bcd_q  <= '0;
      end else if (accept) begin
         cnt    <= CNT_W'(BIN_W);
         bin_sr <= io.bin;
         work   <= '0;
      end else if (state == SHIFT) begin
         cnt    <= cnt - CNT_W'(1);
         bin_sr <= bin_sh;
         work   <= work_sh;
         // Output register updates only here so the previous result survives IDLE and SHIFT.
         if (last_bit) begin
            bcd_q <= work_sh;
         end
      end
   end

   assign io.in_ready  = (state == IDLE);
   assign io.out_valid = (state == DONE);
   assign io.bcd       = bcd_q;
endmodule
